wb_regfile: RTL and testbench

//  Write-back end of the MEM/WB pipeline interface: consumes the MEM/WB register outputs,

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_regfile_if.sv | 32 +++
 rtl/wb_src_mux.sv | 26 ++
 rtl/wb_regfile.sv | 65 ++++++
 tb/tb_wb_regfile.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared widths and write-back source encodings for the MEM/WB write-back stage.
package wb_pkg;
  localparam int DATA_W     = 16;
  localparam int NREGS      = 8;
  localparam int REG_ADDR_W = 3;
  localparam int RETIRE_W   = 16;

  typedef enum logic [1:0] {
    RS_MEM = 2'b00,
    RS_ALU = 2'b01,
    RS_PC  = 2'b10,
    RS_B   = 2'b11
  } regsrc_e;
endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB to write-back bundle; master drives pipeline and read indices, slave is the register file.
interface wb_regfile_if;
  import wb_pkg::*;

  logic [1:0]            RegSrc;
  logic [DATA_W-1:0]     mem_data;
  logic [DATA_W-1:0]     alu_data;
  logic [DATA_W-1:0]     pc_data;
  logic [DATA_W-1:0]     Binput;
  logic                  RegWrt;
  logic                  SendNOP;
  logic [REG_ADDR_W-1:0] write_reg;
  logic [REG_ADDR_W-1:0] read_reg1;
  logic [REG_ADDR_W-1:0] read_reg2;
  logic [DATA_W-1:0]     read_data1;
  logic [DATA_W-1:0]     read_data2;
  logic [DATA_W-1:0]     wb_data;
  logic                  wb_we;
  logic [RETIRE_W-1:0]   retire_cnt;

  modport master (
    output RegSrc, mem_data, alu_data, pc_data, Binput,
    output RegWrt, SendNOP, write_reg, read_reg1, read_reg2,
    input  read_data1, read_data2, wb_data, wb_we, retire_cnt
  );

  modport slave (
    input  RegSrc, mem_data, alu_data, pc_data, Binput,
    input  RegWrt, SendNOP, write_reg, read_reg1, read_reg2,
    output read_data1, read_data2, wb_data, wb_we, retire_cnt
  );
endinterface

// File: rtl/wb_src_mux.sv
// 4:1 write-back source select; purely combinational, also feeds the forwarding path.
module wb_src_mux
  import wb_pkg::*;
(
  input  logic [1:0]        i_sel,
  input  logic [DATA_W-1:0] i_mem,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [DATA_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_dat
);
  regsrc_e w_sel;

  assign w_sel = regsrc_e'(i_sel);

  always_comb begin
    o_dat = i_mem;
    case (w_sel)
      RS_MEM:  o_dat = i_mem;
      RS_ALU:  o_dat = i_alu;
      RS_PC:   o_dat = i_pc;
      RS_B:    o_dat = i_b;
      default: o_dat = i_mem;
    endcase
  end
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: 8x16 register file, two async read ports, retired-instruction counter.
// WB_REGFILE_BYPASS_EN: same-cycle write data is forwarded onto a matching read port.
module wb_regfile
  import wb_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  wb
);
  logic [DATA_W-1:0]   r_regs [NREGS];
  logic [RETIRE_W-1:0] r_retire;
  logic [DATA_W-1:0]   w_wb_data;
  logic                w_we;
  logic [DATA_W-1:0]   w_rd1;
  logic [DATA_W-1:0]   w_rd2;

  wb_src_mux u_src_mux (
    .i_sel (wb.RegSrc),
    .i_mem (wb.mem_data),
    .i_alu (wb.alu_data),
    .i_pc  (wb.pc_data),
    .i_b   (wb.Binput),
    .o_dat (w_wb_data)
  );

  assign w_we       = wb.RegWrt & ~wb.SendNOP;
  assign wb.wb_data = w_wb_data;
  assign wb.wb_we   = w_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[wb.write_reg] <= w_wb_data;
    end
  end

  // Bubbles do not retire; RegWrt plays no part in the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retire <= '0;
    end else if (!wb.SendNOP) begin
      r_retire <= r_retire + RETIRE_W'(1);
    end
  end

  assign wb.retire_cnt = r_retire;

`ifdef WB_REGFILE_BYPASS_EN
  // Gated by rst so a reset read never shows in-flight write data.
  logic w_byp1;
  logic w_byp2;

  assign w_byp1 = rst & w_we & (wb.read_reg1 == wb.write_reg);
  assign w_byp2 = rst & w_we & (wb.read_reg2 == wb.write_reg);
  assign w_rd1  = w_byp1 ? w_wb_data : r_regs[wb.read_reg1];
  assign w_rd2  = w_byp2 ? w_wb_data : r_regs[wb.read_reg2];
`else
  assign w_rd1  = r_regs[wb.read_reg1];
  assign w_rd2  = r_regs[wb.read_reg2];
`endif

  assign wb.read_data1 = w_rd1;
  assign wb.read_data2 = w_rd2;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: source select, NOP suppression, hazards, reset, counter wrap.
module tb_wb_regfile;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [RETIRE_W-1:0] exp_retire;

  wb_regfile_if wb ();

  wb_regfile dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge; the retire model follows the counting rule independently.
  task automatic tick();
    @(posedge clk);
    if (rst && !wb.SendNOP) exp_retire = exp_retire + 16'd1;
    #1;
  endtask

  task automatic write_alu(input logic [2:0] idx, input logic [15:0] val);
    wb.RegSrc = RS_ALU; wb.alu_data = val; wb.write_reg = idx;
    wb.RegWrt = 1'b1; wb.SendNOP = 1'b0;
    tick();
    wb.RegWrt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; exp_retire = '0;
    wb.RegSrc = RS_ALU; wb.mem_data = '0; wb.alu_data = 16'h5A5A; wb.pc_data = '0;
    wb.Binput = '0; wb.RegWrt = 1'b1; wb.SendNOP = 1'b0; wb.write_reg = 3'd1;
    wb.read_reg1 = 3'd1; wb.read_reg2 = 3'd6;
    #1;
    checks++; if (wb.read_data1 !== 16'h0) begin failures++; $display("FAIL reset_rd1: actual=%h required=0000", wb.read_data1); end
    checks++; if (wb.read_data2 !== 16'h0) begin failures++; $display("FAIL reset_rd2: actual=%h required=0000", wb.read_data2); end
    checks++; if (wb.retire_cnt !== 16'h0) begin failures++; $display("FAIL reset_retire: actual=%h required=0000", wb.retire_cnt); end
    checks++; if (wb.wb_we !== 1'b1 || wb.wb_data !== 16'h5A5A) begin failures++; $display("FAIL reset_comb_wb: actual we=%b data=%h required we=1 data=5a5a", wb.wb_we, wb.wb_data); end
    tick(); tick();
    wb.RegWrt = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (wb.read_data1 !== 16'h0) begin failures++; $display("FAIL reset_write_dropped: actual=%h required=0000", wb.read_data1); end
  endtask

  task automatic test_src_select();
    logic [15:0] exp_tab [4];
    exp_tab[0] = 16'h1111; exp_tab[1] = 16'h2222; exp_tab[2] = 16'h3333; exp_tab[3] = 16'h4444;
    wb.mem_data = 16'h1111; wb.alu_data = 16'h2222; wb.pc_data = 16'h3333; wb.Binput = 16'h4444;
    wb.write_reg = 3'd3; wb.read_reg1 = 3'd3; wb.SendNOP = 1'b0;
    for (int s = 0; s < 4; s++) begin
      wb.RegSrc = 2'(s); wb.RegWrt = 1'b1;
      #1;
      checks++; if (wb.wb_data !== exp_tab[s]) begin failures++; $display("FAIL src_wb_data sel=%0d: actual=%h required=%h", s, wb.wb_data, exp_tab[s]); end
      tick();
      wb.RegWrt = 1'b0;
      #1;
      checks++; if (wb.read_data1 !== exp_tab[s]) begin failures++; $display("FAIL src_r3 sel=%0d: actual=%h required=%h", s, wb.read_data1, exp_tab[s]); end
    end
  endtask

  task automatic test_nop();
    logic [15:0] retire_before;
    wb.RegSrc = RS_ALU; wb.alu_data = 16'hBEEF; wb.write_reg = 3'd5;
    wb.RegWrt = 1'b1; wb.SendNOP = 1'b1; wb.read_reg2 = 3'd5;
    #1;
    checks++; if (wb.wb_we !== 1'b0) begin failures++; $display("FAIL nop_we: actual=%b required=0", wb.wb_we); end
    retire_before = exp_retire;
    tick();
    wb.RegWrt = 1'b0;
    #1;
    checks++; if (wb.read_data2 !== 16'h0000) begin failures++; $display("FAIL nop_r5: actual=%h required=0000", wb.read_data2); end
    checks++; if (wb.retire_cnt !== retire_before) begin failures++; $display("FAIL nop_retire: actual=%h required=%h", wb.retire_cnt, retire_before); end
    wb.SendNOP = 1'b0;
  endtask

  task automatic test_same_cycle();
    logic [15:0] exp_now;
    write_alu(3'd2, 16'h1234);
`ifdef WB_REGFILE_BYPASS_EN
    exp_now = 16'hA5A5;
`else
    exp_now = 16'h1234;
`endif
    wb.RegSrc = RS_ALU; wb.alu_data = 16'hA5A5; wb.write_reg = 3'd2;
    wb.RegWrt = 1'b1; wb.SendNOP = 1'b0; wb.read_reg1 = 3'd2; wb.read_reg2 = 3'd2;
    #1;
    checks++; if (wb.read_data1 !== exp_now) begin failures++; $display("FAIL same_cycle_rd1: actual=%h required=%h", wb.read_data1, exp_now); end
    checks++; if (wb.read_data2 !== exp_now) begin failures++; $display("FAIL same_cycle_rd2: actual=%h required=%h", wb.read_data2, exp_now); end
    tick();
    wb.RegWrt = 1'b0;
    #1;
    checks++; if (wb.read_data1 !== 16'hA5A5) begin failures++; $display("FAIL same_cycle_next: actual=%h required=a5a5", wb.read_data1); end
  endtask

  task automatic test_all_regs();
    for (int i = 0; i < 8; i++) write_alu(3'(i), 16'h0100 + 16'(i));
    for (int i = 0; i < 8; i++) begin
      wb.read_reg1 = 3'(i); wb.read_reg2 = 3'(7 - i);
      #1;
      checks++; if (wb.read_data1 !== 16'h0100 + 16'(i)) begin failures++; $display("FAIL all_regs_rd1 r%0d: actual=%h required=%h", i, wb.read_data1, 16'h0100 + 16'(i)); end
      checks++; if (wb.read_data2 !== 16'h0100 + 16'(7 - i)) begin failures++; $display("FAIL all_regs_rd2 r%0d: actual=%h required=%h", 7 - i, wb.read_data2, 16'h0100 + 16'(7 - i)); end
    end
  endtask

  task automatic test_reset_mid();
    checks++; if (wb.retire_cnt !== exp_retire) begin failures++; $display("FAIL pre_reset_retire: actual=%h required=%h", wb.retire_cnt, exp_retire); end
    wb.RegSrc = RS_ALU; wb.alu_data = 16'h7777; wb.write_reg = 3'd4;
    wb.RegWrt = 1'b1; wb.SendNOP = 1'b0; wb.read_reg1 = 3'd4; wb.read_reg2 = 3'd7;
    rst = 1'b0; exp_retire = '0;
    #1;
    checks++; if (wb.read_data1 !== 16'h0) begin failures++; $display("FAIL mid_reset_rd1: actual=%h required=0000", wb.read_data1); end
    checks++; if (wb.read_data2 !== 16'h0) begin failures++; $display("FAIL mid_reset_rd2: actual=%h required=0000", wb.read_data2); end
    checks++; if (wb.retire_cnt !== 16'h0) begin failures++; $display("FAIL mid_reset_retire: actual=%h required=0000", wb.retire_cnt); end
    tick();
    wb.RegWrt = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (wb.read_data1 !== 16'h0) begin failures++; $display("FAIL mid_reset_drop: actual=%h required=0000", wb.read_data1); end
    write_alu(3'd4, 16'h7777);
    #1;
    checks++; if (wb.read_data1 !== 16'h7777) begin failures++; $display("FAIL first_write_after_reset: actual=%h required=7777", wb.read_data1); end
    checks++; if (wb.retire_cnt !== 16'd1) begin failures++; $display("FAIL retire_after_reset: actual=%h required=0001", wb.retire_cnt); end
  endtask

  task automatic test_retire_wrap();
    rst = 1'b0; exp_retire = '0;
    wb.RegWrt = 1'b0; wb.SendNOP = 1'b0;
    #2;
    rst = 1'b1;
    repeat (16'hFFFF) tick();
    checks++; if (wb.retire_cnt !== 16'hFFFF) begin failures++; $display("FAIL retire_max: actual=%h required=ffff", wb.retire_cnt); end
    tick();
    checks++; if (wb.retire_cnt !== 16'h0000) begin failures++; $display("FAIL retire_wrap: actual=%h required=0000", wb.retire_cnt); end
    checks++; if (wb.retire_cnt !== exp_retire) begin failures++; $display("FAIL retire_model: actual=%h required=%h", wb.retire_cnt, exp_retire); end
  endtask

  initial begin
    test_reset();
    test_src_select();
    test_nop();
    test_same_cycle();
    test_all_regs();
    test_reset_mid();
    test_retire_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
